// File: rtl/bp_pkg.sv
// Shared constants for the 2-bit branch predictor: counter encodings and
// the values written when a resolving branch misses in the cache.
package bp_pkg;

  localparam int BP_CWIDTH = 2;

  typedef logic [BP_CWIDTH-1:0] bp_ctr_t;

  localparam bp_ctr_t BP_SNT = 2'b00;
  localparam bp_ctr_t BP_WNT = 2'b01;
  localparam bp_ctr_t BP_WT  = 2'b10;
  localparam bp_ctr_t BP_ST  = 2'b11;

  localparam bp_ctr_t BP_ALLOC_T  = BP_WT;
  localparam bp_ctr_t BP_ALLOC_NT = BP_WNT;

endpackage

// File: rtl/bp_cache.sv
// Direct-mapped cache of 2-bit branch counters: two read ports (fetch and
// execute) and one write port. Index is the word address modulo LINES.
module bp_cache
  import bp_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int LINES  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] ra0,
  output bp_ctr_t           dout0,
  output logic              hit0,
  input  logic [AWIDTH-1:0] ra1,
  output bp_ctr_t           dout1,
  output logic              hit1,
  input  logic              we,
  input  logic [AWIDTH-1:0] wa,
  input  bp_ctr_t           din
);

  localparam int IW = $clog2(LINES);
  localparam int TW = AWIDTH - IW - 2;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]    tag_q [LINES];
  logic [TW-1:0]    tag_d [LINES];
  bp_ctr_t          ctr_q [LINES];
  bp_ctr_t          ctr_d [LINES];

  logic [IW-1:0] idx0, idx1, widx;
  logic [TW-1:0] tag0, tag1, wtag;
  logic          unused_low_bits;

  assign idx0 = ra0[IW+1:2];
  assign idx1 = ra1[IW+1:2];
  assign widx = wa[IW+1:2];
  assign tag0 = ra0[AWIDTH-1:IW+2];
  assign tag1 = ra1[AWIDTH-1:IW+2];
  assign wtag = wa[AWIDTH-1:IW+2];
  assign unused_low_bits = ^{ra0[1:0], ra1[1:0], wa[1:0]};

  assign hit0  = valid_q[idx0] && (tag_q[idx0] == tag0);
  assign dout0 = ctr_q[idx0];
  assign hit1  = valid_q[idx1] && (tag_q[idx1] == tag1);
  assign dout1 = ctr_q[idx1];

  // Write-port next state for the line arrays.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    ctr_d   = ctr_q;
    if (we) begin
      valid_d[widx] = 1'b1;
      tag_d[widx]   = wtag;
      ctr_d[widx]   = din;
    end else begin
      valid_d = valid_q;
    end
  end

  // Line storage; reset only clears the valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    tag_q <= tag_d;
    ctr_q <= ctr_d;
  end

endmodule

// File: rtl/bp_sat_update.sv
// Next-state logic for one 2-bit saturating counter; a miss allocates
// the weak state in the resolved direction.
module bp_sat_update
  import bp_pkg::*;
(
  input  logic    hit,
  input  logic    taken,
  input  bp_ctr_t ctr_in,
  output bp_ctr_t ctr_out
);

  // Saturating up/down step, or weak allocation on a miss.
  always_comb begin
    ctr_out = BP_WNT;
    if (!hit) begin
      ctr_out = taken ? BP_ALLOC_T : BP_ALLOC_NT;
    end else if (taken) begin
      ctr_out = (ctr_in == BP_ST) ? BP_ST : bp_ctr_t'(ctr_in + 2'd1);
    end else begin
      ctr_out = (ctr_in == BP_SNT) ? BP_SNT : bp_ctr_t'(ctr_in - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic 2-bit branch predictor: fetch-side prediction with same-cycle
// bypass of the execute-side update, plus saturating branch statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int LINES  = 128,
  parameter int CWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] pc_guess,
  input  logic              is_br_guess,
  output logic              br_pred_taken,
  input  logic [AWIDTH-1:0] pc_check,
  input  logic              is_br_check,
  input  logic              br_taken_check,
  input  logic              pred_taken_check,
  output logic              mispredict,
  input  logic              stats_clear,
  output logic [CWIDTH-1:0] br_count,
  output logic [CWIDTH-1:0] mispred_count
);

  localparam logic [CWIDTH-1:0] CNT_MAX = {CWIDTH{1'b1}};
  localparam logic [CWIDTH-1:0] CNT_ONE = CWIDTH'(1);

  bp_ctr_t dout0, dout1, din;
  logic    hit0, hit1, we, bypass;

  logic [CWIDTH-1:0] br_count_q, br_count_d;
  logic [CWIDTH-1:0] mispred_count_q, mispred_count_d;

  assign we = is_br_check & ~reset;

  bp_cache #(.AWIDTH(AWIDTH), .LINES(LINES)) u_cache (
    .clk   (clk),
    .reset (reset),
    .ra0   (pc_guess),
    .dout0 (dout0),
    .hit0  (hit0),
    .ra1   (pc_check),
    .dout1 (dout1),
    .hit1  (hit1),
    .we    (we),
    .wa    (pc_check),
    .din   (din)
  );

  bp_sat_update u_upd (
    .hit     (hit1),
    .taken   (br_taken_check),
    .ctr_in  (dout1),
    .ctr_out (din)
  );

  assign bypass     = is_br_check && (pc_check == pc_guess);
  assign mispredict = is_br_check & (pred_taken_check ^ br_taken_check);

  // Fetch prediction; a write to the same PC this cycle overrides the cache.
  always_comb begin
    br_pred_taken = 1'b0;
    if (!is_br_guess) begin
      br_pred_taken = 1'b0;
    end else if (bypass) begin
      br_pred_taken = din[1];
    end else if (hit0) begin
      br_pred_taken = dout0[1];
    end else begin
      br_pred_taken = 1'b0;
    end
  end

  // Statistics next state: clear wins, increments saturate.
  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (stats_clear) begin
      br_count_d      = '0;
      mispred_count_d = '0;
    end else if (is_br_check) begin
      if (br_count_q != CNT_MAX) begin
        br_count_d = br_count_q + CNT_ONE;
      end else begin
        br_count_d = br_count_q;
      end
      if (mispredict && (mispred_count_q != CNT_MAX)) begin
        mispred_count_d = mispred_count_q + CNT_ONE;
      end else begin
        mispred_count_d = mispred_count_q;
      end
    end else begin
      br_count_d      = br_count_q;
      mispred_count_d = mispred_count_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized scoreboard bench for branch_predictor with a table-based
// reference model of the direct-mapped 2-bit counter cache.
module tb_branch_predictor;

  localparam int AW    = 32;
  localparam int LINES = 128;
  localparam int CW    = 32;
  localparam int IW    = $clog2(LINES);
  localparam longint CMAX = (64'd1 << CW) - 64'd1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc_guess = '0;
  logic          is_br_guess = 1'b0;
  logic          br_pred_taken;
  logic [AW-1:0] pc_check = '0;
  logic          is_br_check = 1'b0;
  logic          br_taken_check = 1'b0;
  logic          pred_taken_check = 1'b0;
  logic          mispredict;
  logic          stats_clear = 1'b0;
  logic [CW-1:0] br_count;
  logic [CW-1:0] mispred_count;

  branch_predictor #(.AWIDTH(AW), .LINES(LINES), .CWIDTH(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_guess         (pc_guess),
    .is_br_guess      (is_br_guess),
    .br_pred_taken    (br_pred_taken),
    .pc_check         (pc_check),
    .is_br_check      (is_br_check),
    .br_taken_check   (br_taken_check),
    .pred_taken_check (pred_taken_check),
    .mispredict       (mispredict),
    .stats_clear      (stats_clear),
    .br_count         (br_count),
    .mispred_count    (mispred_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pred;
    logic          mis;
    logic [CW-1:0] brc;
    logic [CW-1:0] mic;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: per-line valid/tag/counter, counters as plain integers.
  bit          m_valid [LINES];
  longint      m_tag   [LINES];
  int          m_ctr   [LINES];
  longint      cnt_br  = 0;
  longint      cnt_mis = 0;

  function automatic int line_of(logic [AW-1:0] pc);
    return int'((pc / 4) % LINES);
  endfunction

  function automatic longint tag_of(logic [AW-1:0] pc);
    return longint'(pc) / (4 * LINES);
  endfunction

  function automatic bit model_hit(logic [AW-1:0] pc);
    return m_valid[line_of(pc)] && (m_tag[line_of(pc)] == tag_of(pc));
  endfunction

  function automatic int next_ctr(logic [AW-1:0] pc, logic taken);
    int c;
    if (!model_hit(pc)) return taken ? 2 : 1;
    c = m_ctr[line_of(pc)];
    if (taken) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic compare(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      compare("pred",      {31'd0, br_pred_taken}, {31'd0, mon_e.pred});
      compare("mispred",   {31'd0, mispredict},    {31'd0, mon_e.mis});
      compare("br_count",  br_count,               mon_e.brc);
      compare("mis_count", mispred_count,          mon_e.mic);
    end
  end

  // One cycle of stimulus; want >= 0 additionally checks br_pred_taken against a constant.
  task automatic step(input logic [AW-1:0] gpc, input logic gbr,
                      input logic [AW-1:0] cpc, input logic cbr, input logic ct,
                      input logic cp, input logic clr, input logic rst, input int want);
    exp_t e;
    int   nc;
    pc_guess = gpc; is_br_guess = gbr;
    pc_check = cpc; is_br_check = cbr; br_taken_check = ct; pred_taken_check = cp;
    stats_clear = clr; reset = rst;
    nc = next_ctr(cpc, ct);
    if (!gbr)                     e.pred = 1'b0;
    else if (cbr && cpc == gpc)   e.pred = (nc >= 2);
    else if (model_hit(gpc))      e.pred = (m_ctr[line_of(gpc)] >= 2);
    else                          e.pred = 1'b0;
    e.mis = cbr && (cp != ct);
    e.brc = cnt_br[CW-1:0];
    e.mic = cnt_mis[CW-1:0];
    sb.push_back(e);
    @(negedge clk);
    if (want >= 0) compare("pred_const", {31'd0, br_pred_taken}, want);
    @(posedge clk);
    if (rst) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      cnt_br = 0; cnt_mis = 0;
    end else begin
      if (cbr) begin
        m_valid[line_of(cpc)] = 1'b1;
        m_tag[line_of(cpc)]   = tag_of(cpc);
        m_ctr[line_of(cpc)]   = nc;
      end
      if (clr) begin
        cnt_br = 0; cnt_mis = 0;
      end else if (cbr) begin
        if (cnt_br < CMAX) cnt_br++;
        if (cp != ct && cnt_mis < CMAX) cnt_mis++;
      end
    end
    #1;
  endtask

  task automatic chk(input logic [AW-1:0] pc, input logic taken, input logic pred);
    step(32'h0, 1'b0, pc, 1'b1, taken, pred, 1'b0, 1'b0, -1);
  endtask

  task automatic guess(input logic [AW-1:0] pc, input int want);
    step(pc, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, want);
  endtask

  task automatic check_counts(input int eb, input int em);
    compare("br_count_const",  br_count,      eb);
    compare("mis_count_const", mispred_count, em);
  endtask

  initial begin
    logic [AW-1:0] gpc, cpc;
    @(posedge clk); #1;
    step(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    step(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    check_counts(0, 0);

    // Cold miss then allocate weak-taken.
    guess(32'h100, 0);
    chk(32'h100, 1'b1, 1'b0);
    check_counts(1, 1);
    guess(32'h100, 1);

    // Saturation both ways.
    repeat (4) chk(32'h200, 1'b1, 1'b1);
    guess(32'h200, 1);
    chk(32'h200, 1'b0, 1'b1);
    guess(32'h200, 1);
    chk(32'h200, 1'b0, 1'b1);
    guess(32'h200, 0);
    repeat (3) chk(32'h200, 1'b0, 1'b0);
    chk(32'h200, 1'b1, 1'b0);
    guess(32'h200, 0);

    // Bypass: counter at 01, same-cycle taken check flips prediction.
    chk(32'h300, 1'b0, 1'b0);
    guess(32'h300, 0);
    step(32'h300, 1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    guess(32'h300, 1);

    // Aliasing: 0x600 shares the line of 0x400 with another tag.
    chk(32'h400, 1'b1, 1'b0);
    guess(32'h400, 1);
    chk(32'h600, 1'b0, 1'b0);
    guess(32'h400, 0);
    guess(32'h600, 0);

    // Statistics: 10 checks with 3 mismatches, then clear alongside a check.
    step(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    check_counts(0, 0);
    for (int i = 0; i < 10; i++) begin
      chk(32'h700 + 32'(i * 4), 1'b1, (i % 3 == 0 && i < 9) ? 1'b0 : 1'b1);
    end
    check_counts(10, 3);
    step(32'h0, 1'b0, 32'h704, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    check_counts(0, 0);

    // Reset with a check in flight.
    repeat (3) chk(32'h500, 1'b1, 1'b1);
    guess(32'h500, 1);
    step(32'h0, 1'b0, 32'h500, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    check_counts(0, 0);
    guess(32'h500, 0);

    // Random traffic over a small PC pool to force hits, aliasing and bypass.
    for (int n = 0; n < 3000; n++) begin
      gpc = AW'(($urandom_range(0, 3) << (IW + 2)) | ($urandom_range(0, 7) << 2));
      cpc = AW'(($urandom_range(0, 3) << (IW + 2)) | ($urandom_range(0, 7) << 2));
      step(gpc, 1'($urandom_range(0, 3) != 0), cpc, 1'($urandom_range(0, 2) != 0),
           1'($urandom), 1'($urandom), 1'($urandom_range(0, 40) == 0),
           1'($urandom_range(0, 150) == 0), -1);
    end

    reset = 1'b0; is_br_check = 1'b0; is_br_guess = 1'b0; stats_clear = 1'b0;
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
